spi_matrix_loader: RTL and testbench
====================================

Name: spi_matrix_loader

Overview:
- SPI slave front end that sits upstream of the matrix-multiply core inside top.
- Oversamples the external spi_clk, cs and mosi pins in the hz100 domain and deserializes bytes.
- Assembles two N×N operand matrices, A then B, into flat registers.
- Hands the complete operand set to the core through a valid/ack handshake.

Parameters:
- N, 2, matrix dimension; A and B are both N×N.
- W, 8, element width in bits; one SPI word is W bits, MSB first.

Ports:
- hz100  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- spi_clk  input  1  raw SPI clock, mode 0. mosi is sampled on its rising edge.
- cs  input  1  raw chip select, active-low.
- mosi  input  1  raw serial data.
- a_flat  output  N*N*W  matrix A, row-major. Element k occupies bits [k*W +: W].
- b_flat  output  N*N*W  matrix B, same layout as a_flat.
- mats_valid  output  1  A and B are complete and stable.
- mats_ack  input  1  core has taken the operands.
- busy  output  1  a frame is in progress (RECV state).
- frame_err  output  1  one-cycle pulse when a frame is aborted early.
- overrun  output  1  one-cycle pulse when a frame is rejected because the previous set is still unacknowledged.

Behaviour:
- Reset values: a_flat=0, b_flat=0, mats_valid=0, busy=0, frame_err=0, overrun=0, state=IDLE. All counters and the shift register are 0.
- Reset asserted mid-frame or mid-handshake discards everything. The next frame starts cleanly.
- Synchronization:
  - spi_clk, cs and mosi each pass through a 2-flop synchronizer.
  - Edge detection uses a third flop.
  - Requirement: spi_clk high and low phases are each at least 3 hz100 periods.
- cs_fall and cs_rise are detected on the synchronized cs. sclk_rise is detected on the synchronized spi_clk.
- States: IDLE, RECV, FULL, DROP.
- IDLE:
  - cs_fall with mats_valid=0 → RECV. Bit counter and element counter are cleared.
  - cs_fall with mats_valid=1 → DROP, and overrun pulses in that cycle.
- RECV:
  - Each sclk_rise shifts the synchronized mosi into the shift register LSB. The bit counter increments.
  - On the W-th bit, the assembled word is written to element slot elem. elem runs 0..2*N*N-1: slots 0..N*N-1 go to A, the rest to B.
  - The bit counter wraps to 0 and elem increments.
  - Final element written → FULL. mats_valid rises the cycle after the sclk_rise that captured the last bit.
  - cs_rise before the final element → IDLE. frame_err pulses for one cycle. mats_valid stays 0.
  - On abort, partially written slots keep their new contents, but the set is never validated.
  - sclk_rise and cs_rise in the same cycle: cs_rise wins and the bit is discarded.
- FULL:
  - Extra sclk_rise events are ignored. No flag is raised.
  - cs_rise → IDLE. This is not an error.
  - mats_valid remains set across the FULL→IDLE transition.
- DROP:
  - All bits are ignored.
  - cs_rise → IDLE.
- Handshake:
  - mats_valid holds until a cycle with mats_ack=1. It is 0 from the next cycle.
  - a_flat and b_flat do not change while mats_valid=1.
  - mats_ack while mats_valid=0 is ignored.
  - mats_ack in the same cycle as a cs_fall: the ack is applied first, and the frame is accepted into RECV, not DROP.
- busy = (state == RECV).

Decomposition:
- Package matmul_pkg holds:
  - localparams N, W, ELEMS = 2*N*N, and counter widths $clog2(W) and $clog2(ELEMS).
  - The loader state enum {IDLE, RECV, FULL, DROP}.
  - Flat-vector width constants shared with the compute core.
- One sub-module, sync_edge: a 2-flop synchronizer plus rise/fall detect. It is instantiated three times.

Test Plan:
- Normal load, N=2, W=8: send bytes 0x01..0x08 in one cs-low frame → a_flat=0x04030201, b_flat=0x08070605, mats_valid=1 one cycle after the last captured bit, busy=0, frame_err=0.
- Handshake: hold mats_ack=0 for 20 cycles, then pulse it for 1 cycle → mats_valid stays 1 and the operands stay stable, then mats_valid=0 the next cycle.
- Abort: send 3 bytes plus 5 bits, then raise cs → frame_err pulses once, mats_valid stays 0. A following full frame of 0x10..0x17 gives a_flat=0x13121110 and b_flat=0x17161514.
- Overrun: complete frame 0x01..0x08, no ack, then send frame 0xFF×8 → overrun pulses at cs_fall and a_flat/b_flat are unchanged. After ack, a new frame loads correctly.
- Reset mid-frame: assert reset after 4 bytes, release, then send 0x21..0x28 → a_flat=0x24232221, b_flat=0x28272625, no frame_err.
- Trailing bits: send 9 bytes in one frame → the first 8 are loaded, the 9th is ignored, and overrun and frame_err both stay 0.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared constants and types for the SPI operand loader and the matrix-multiply core.
package matmul_pkg;

  localparam int N          = 2;
  localparam int W          = 8;
  localparam int MAT_ELEMS  = N * N;
  localparam int ELEMS      = 2 * MAT_ELEMS;
  localparam int BIT_CNT_W  = $clog2(W);
  localparam int ELEM_CNT_W = $clog2(ELEMS);
  localparam int FLAT_W     = MAT_ELEMS * W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    FULL = 2'd2,
    DROP = 2'd3
  } loader_state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for one raw pin, plus a third flop for rise/fall detection.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic hz100,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge hz100) begin
    if (reset) begin
      meta <= RST_VAL;
      sync <= RST_VAL;
      prev <= RST_VAL;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/spi_matrix_loader.sv
// SPI mode-0 slave that assembles operand matrices A then B and offers them to the
// matrix core over a valid/ack handshake.
//
// state | meaning
// IDLE  | waiting for cs to fall
// RECV  | shifting words into A/B slots
// FULL  | all slots written, ignoring further bits until cs rises
// DROP  | previous set still unacknowledged, frame discarded
module spi_matrix_loader
  import matmul_pkg::*;
(
  input  logic              hz100,
  input  logic              reset,
  input  logic              spi_clk,
  input  logic              cs,
  input  logic              mosi,
  output logic [FLAT_W-1:0] a_flat,
  output logic [FLAT_W-1:0] b_flat,
  output logic              mats_valid,
  input  logic              mats_ack,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);

  loader_state_t state, state_nxt;

  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [ELEM_CNT_W-1:0] elem_cnt;
  logic [W-1:0]          shift_reg;
  logic [W-1:0]          word;

  logic sclk_rise, cs_rise, cs_fall, mosi_s;
  logic sclk_level_unused, sclk_fall_unused, cs_level_unused;
  logic mosi_rise_unused, mosi_fall_unused;

  logic valid_eff, start_frame, take_bit, word_done, last_word;

  sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .hz100 (hz100),
    .reset (reset),
    .din   (spi_clk),
    .level (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall_unused)
  );

  // cs idles high, so its synchronizer resets high to avoid a false edge.
  sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .hz100 (hz100),
    .reset (reset),
    .din   (cs),
    .level (cs_level_unused),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .hz100 (hz100),
    .reset (reset),
    .din   (mosi),
    .level (mosi_s),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  // An ack arriving with cs_fall frees the set first, so the frame is accepted.
  assign valid_eff   = mats_valid & ~mats_ack;
  assign start_frame = (state == IDLE) & cs_fall & ~valid_eff;
  assign take_bit    = (state == RECV) & sclk_rise & ~cs_rise;
  assign word        = {shift_reg[W-2:0], mosi_s};
  assign word_done   = (bit_cnt == BIT_CNT_W'(W - 1));
  assign last_word   = word_done & (elem_cnt == ELEM_CNT_W'(ELEMS - 1));

  always_ff @(posedge hz100) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cs_fall) state_nxt = valid_eff ? DROP : RECV;
      RECV: begin
        if (cs_rise)                    state_nxt = IDLE;
        else if (take_bit && last_word) state_nxt = FULL;
      end
      FULL: if (cs_rise) state_nxt = IDLE;
      DROP: if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == RECV);
    frame_err = (state == RECV) & cs_rise;
    overrun   = (state == IDLE) & cs_fall & valid_eff;
  end

  always_ff @(posedge hz100) begin
    if (reset) begin
      bit_cnt    <= '0;
      elem_cnt   <= '0;
      shift_reg  <= '0;
      a_flat     <= '0;
      b_flat     <= '0;
      mats_valid <= 1'b0;
    end else begin
      if (start_frame) begin
        bit_cnt   <= '0;
        elem_cnt  <= '0;
        shift_reg <= '0;
      end else if (take_bit) begin
        shift_reg <= word;
        if (word_done) begin
          bit_cnt  <= '0;
          elem_cnt <= elem_cnt + 1'b1;
          for (int k = 0; k < MAT_ELEMS; k++) begin
            if (elem_cnt == ELEM_CNT_W'(k))             a_flat[k*W +: W] <= word;
            if (elem_cnt == ELEM_CNT_W'(k + MAT_ELEMS)) b_flat[k*W +: W] <= word;
          end
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end

      if (take_bit && last_word) mats_valid <= 1'b1;
      else if (mats_ack)         mats_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_matrix_loader.sv
// Randomized bench for spi_matrix_loader against a frame-level operand model.
module tb_spi_matrix_loader;
  import matmul_pkg::*;

  typedef logic [7:0] byte_q_t[$];

  logic              hz100 = 1'b0;
  logic              reset;
  logic              spi_clk;
  logic              cs;
  logic              mosi;
  logic              mats_ack;
  logic [FLAT_W-1:0] a_flat;
  logic [FLAT_W-1:0] b_flat;
  logic              mats_valid;
  logic              busy;
  logic              frame_err;
  logic              overrun;

  always #5 hz100 = ~hz100;

  spi_matrix_loader dut (
    .hz100      (hz100),
    .reset      (reset),
    .spi_clk    (spi_clk),
    .cs         (cs),
    .mosi       (mosi),
    .a_flat     (a_flat),
    .b_flat     (b_flat),
    .mats_valid (mats_valid),
    .mats_ack   (mats_ack),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  int checks = 0;
  int errors = 0;

  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int exp_ferr = 0;
  int exp_ovr  = 0;

  logic [7:0] exp_elem[ELEMS];
  logic       exp_valid;
  logic       v_after2;
  logic       v_after3;

  always @(negedge hz100) begin
    if (frame_err) ferr_cnt++;
    if (overrun)   ovr_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge hz100);
  endtask

  function automatic logic [FLAT_W-1:0] model_mat(input int base);
    logic [FLAT_W-1:0] r;
    r = '0;
    for (int k = 0; k < N*N; k++) r[k*8 +: 8] = exp_elem[base + k];
    return r;
  endfunction

  // Four hz100 periods per SPI phase; mats_valid is sampled 2 and 3 edges after the rise.
  task automatic send_bit(input logic b);
    spi_clk = 1'b0;
    mosi    = b;
    cycles(4);
    spi_clk = 1'b1;
    cycles(2);
    v_after2 = mats_valid;
    cycles(1);
    v_after3 = mats_valid;
    cycles(1);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(b[7-i]);
  endtask

  task automatic frame_end();
    spi_clk = 1'b0;
    cycles(4);
    cs = 1'b1;
    cycles(6);
  endtask

  task automatic compare_state(input string tag);
    chk({tag, "_a"},     a_flat,     model_mat(0));
    chk({tag, "_b"},     b_flat,     model_mat(N*N));
    chk({tag, "_valid"}, mats_valid, exp_valid);
    chk({tag, "_busy"},  busy,       1'b0);
    chk({tag, "_ferr"},  ferr_cnt,   exp_ferr);
    chk({tag, "_ovr"},   ovr_cnt,    exp_ovr);
  endtask

  task automatic do_ack(input string tag);
    mats_ack = 1'b1;
    chk({tag, "_pre_ack"}, mats_valid, exp_valid);
    cycles(1);
    mats_ack  = 1'b0;
    exp_valid = 1'b0;
    chk({tag, "_post_ack"}, mats_valid, 1'b0);
  endtask

  task automatic run_frame(input string tag, input byte_q_t bytes, input int extra_bits,
                           input bit ack_at_fall);
    logic was_valid;
    cs = 1'b0;
    if (ack_at_fall) begin
      cycles(2);
      mats_ack = 1'b1;
      cycles(1);
      mats_ack  = 1'b0;
      exp_valid = 1'b0;
      cycles(3);
    end else begin
      cycles(6);
    end
    was_valid = exp_valid;
    chk({tag, "_busy_start"}, busy, !was_valid);
    foreach (bytes[i]) begin
      send_bits(bytes[i], 8);
      if (i == ELEMS - 1 && !was_valid) begin
        chk({tag, "_valid_early"}, v_after2, 1'b0);
        chk({tag, "_valid_lat"},   v_after3, 1'b1);
      end
    end
    if (extra_bits > 0) send_bits(8'($urandom), extra_bits);
    frame_end();

    if (was_valid) begin
      exp_ovr++;
    end else begin
      for (int i = 0; i < bytes.size() && i < ELEMS; i++) exp_elem[i] = bytes[i];
      if (bytes.size() >= ELEMS) exp_valid = 1'b1;
      else                       exp_ferr++;
    end
    compare_state(tag);
  endtask

  function automatic byte_q_t seq_bytes(input logic [7:0] first, input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(first + 8'(i));
    return q;
  endfunction

  function automatic byte_q_t rand_bytes(input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  initial begin
    byte_q_t q;
    logic [FLAT_W-1:0] a_hold, b_hold;
    int sel;

    reset    = 1'b1;
    cs       = 1'b1;
    spi_clk  = 1'b0;
    mosi     = 1'b0;
    mats_ack = 1'b0;
    for (int i = 0; i < ELEMS; i++) exp_elem[i] = 8'h00;
    exp_valid = 1'b0;
    cycles(5);
    chk("rst_a",       a_flat,     '0);
    chk("rst_b",       b_flat,     '0);
    chk("rst_valid",   mats_valid, 1'b0);
    chk("rst_busy",    busy,       1'b0);
    chk("rst_ferr",    frame_err,  1'b0);
    chk("rst_overrun", overrun,    1'b0);
    reset = 1'b0;
    cycles(5);

    run_frame("normal", seq_bytes(8'h01, 8), 0, 1'b0);
    chk("normal_a_lit", a_flat, 32'h04030201);
    chk("normal_b_lit", b_flat, 32'h08070605);

    a_hold = a_flat;
    b_hold = b_flat;
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      if (i == 19) begin
        chk("hold_valid", mats_valid, 1'b1);
        chk("hold_a",     a_flat,     a_hold);
        chk("hold_b",     b_flat,     b_hold);
      end
    end
    do_ack("handshake");
    do_ack("stray_ack");

    q = seq_bytes(8'h30, 3);
    run_frame("abort", q, 5, 1'b0);
    run_frame("after_abort", seq_bytes(8'h10, 8), 0, 1'b0);
    chk("after_abort_a_lit", a_flat, 32'h13121110);
    chk("after_abort_b_lit", b_flat, 32'h17161514);
    do_ack("after_abort");

    run_frame("ovr_load", seq_bytes(8'h01, 8), 0, 1'b0);
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(8'hFF);
    run_frame("ovr_drop", q, 0, 1'b0);
    do_ack("ovr");
    run_frame("ovr_reload", rand_bytes(8), 0, 1'b0);
    do_ack("ovr_reload");

    cs = 1'b0;
    cycles(6);
    send_bits(8'hA5, 8);
    send_bits(8'h5A, 8);
    send_bits(8'hC3, 8);
    send_bits(8'h3C, 8);
    reset   = 1'b1;
    cs      = 1'b1;
    spi_clk = 1'b0;
    cycles(3);
    reset = 1'b0;
    cycles(6);
    for (int i = 0; i < ELEMS; i++) exp_elem[i] = 8'h00;
    exp_valid = 1'b0;
    compare_state("mid_reset");
    run_frame("post_reset", seq_bytes(8'h21, 8), 0, 1'b0);
    chk("post_reset_a_lit", a_flat, 32'h24232221);
    chk("post_reset_b_lit", b_flat, 32'h28272625);

    run_frame("ack_at_fall", rand_bytes(8), 0, 1'b1);
    do_ack("ack_at_fall");

    run_frame("trailing", rand_bytes(9), 0, 1'b0);
    do_ack("trailing");

    for (int it = 0; it < 8; it++) begin
      sel = int'($urandom_range(0, 3));
      if (exp_valid && ($urandom_range(0, 1) == 1)) do_ack("rnd");
      case (sel)
        0: run_frame("rnd_full",  rand_bytes(8), int'($urandom_range(0, 7)), 1'b0);
        1: run_frame("rnd_abort", rand_bytes(int'($urandom_range(0, 7))),
                     int'($urandom_range(0, 7)), 1'b0);
        2: run_frame("rnd_ackfall", rand_bytes(8), 0, exp_valid);
        default: run_frame("rnd_long", rand_bytes(9), 0, 1'b0);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
